// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state type and defaults for the bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus; ovf exists only with SERIAL_SUBTRACTOR_OVF_EN
interface serial_subtractor_if #(parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf;
  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b, one bit per clock; SERIAL_SUBTRACTOR_OVF_EN adds signed overflow
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH) + 1;
  serial_state_t state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic borrow_q, borrow_d, bout_q, bout_d, d, bnext, load, run, last;
  full_subtractor u_fs (.x(a_sr_q[0]), .y(b_sr_q[0]), .bin(borrow_q), .d(d), .bo(bnext));
  assign run = state_q == RUN;
  assign load = s.start && !run;
  assign last = run && cnt_q == CW'(WIDTH - 1);
  // diff/bout load on the final RUN edge so they are already valid during DONE
  always_comb begin
    state_d = load ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_sr_d = load ? s.a : run ? a_sr_q >> 1 : a_sr_q;
    b_sr_d = load ? s.b : run ? b_sr_q >> 1 : b_sr_q;
    r_d = run ? {d, r_q[WIDTH-1:1]} : r_q;
    borrow_d = load ? 1'b0 : run ? bnext : borrow_q;
    cnt_d = load ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    diff_d = last ? r_d : diff_q;
    bout_d = last ? bnext : bout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q <= '0;
      b_sr_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      borrow_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      borrow_q <= borrow_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end
  assign s.busy = run;
  assign s.done = state_q == DONE;
  assign s.diff = diff_q;
  assign s.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
  always_comb begin
    a_msb_d = load ? s.a[WIDTH-1] : a_msb_q;
    b_msb_d = load ? s.b[WIDTH-1] : b_msb_q;
    ovf_d = last ? (a_msb_q != b_msb_q) && (r_d[WIDTH-1] != a_msb_q) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q <= ovf_d;
    end
  end
  assign s.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, handshake corner cases and random sweep against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  serial_subtractor_if #(.WIDTH(W)) sif ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(sif));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic bout;
    logic ovf;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask

  // start pulse, then wait (bounded) for done; returns edges from start to done and busy cycles seen
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, output int lat, output int bc);
    sif.start = 1'b1;
    sif.a = av;
    sif.b = bv;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    sif.a = 8'($urandom);
    sif.b = 8'($urandom);
    lat = 0;
    bc = 0;
    while (!sif.done && lat < 20) begin
      bc += int'(sif.busy);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_model(input string n, input logic [7:0] av, input logic [7:0] bv);
    int sd;
    sd = int'($signed(av)) - int'($signed(bv));
    chk({n, " diff"}, 32'(sif.diff), (int'(av) - int'(bv)) & 32'hFF);
    chk({n, " bout"}, 32'(sif.bout), 32'(int'(av) < int'(bv)));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({n, " ovf"}, 32'(sif.ovf), 32'(sd > 127 || sd < -128));
`else
    if (sd > 1000) $display("unreachable");
`endif
  endtask

  initial begin
    int lat, bc, nd;
    logic [7:0] ra, rb;
    vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vt[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vt[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    rst = 1'b1;
    sif.start = 1'b0;
    sif.a = '0;
    sif.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(sif.busy), 0);
    chk("reset done", 32'(sif.done), 0);
    chk("reset diff", 32'(sif.diff), 0);
    chk("reset bout", 32'(sif.bout), 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("reset ovf", 32'(sif.ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, lat, bc);
      chk($sformatf("vec%0d latency", i), lat, W);
      chk($sformatf("vec%0d busy cycles", i), bc, W);
      chk($sformatf("vec%0d diff", i), 32'(sif.diff), 32'(vt[i].diff));
      chk($sformatf("vec%0d bout", i), 32'(sif.bout), 32'(vt[i].bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk($sformatf("vec%0d ovf", i), 32'(sif.ovf), 32'(vt[i].ovf));
`endif
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 32'(sif.done), 0);
      chk($sformatf("vec%0d diff held", i), 32'(sif.diff), 32'(vt[i].diff));
    end

    // start while busy is ignored, then back-to-back start in the DONE cycle
    sif.start = 1'b1;
    sif.a = 8'hA0;
    sif.b = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a = 8'hFF;
    sif.b = 8'hFF;
    @(negedge clk);
    sif.start = 1'b0;
    lat = 0;
    while (!sif.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy-start done timing", lat, W - 2);
    chk("busy-start diff", 32'(sif.diff), 32'h91);
    chk("busy-start bout", 32'(sif.bout), 0);
    run_op(8'h10, 8'h20, lat, bc);
    chk("b2b latency", lat, W);
    chk("b2b diff", 32'(sif.diff), 32'hF0);
    chk("b2b bout", 32'(sif.bout), 1);
    @(negedge clk);

    // reset during RUN
    sif.start = 1'b1;
    sif.a = 8'h55;
    sif.b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid busy", 32'(sif.busy), 0);
    chk("rst-mid diff", 32'(sif.diff), 0);
    chk("rst-mid bout", 32'(sif.bout), 0);
    nd = 0;
    repeat (12) begin
      nd += int'(sif.done);
      @(negedge clk);
    end
    chk("rst-mid no done", nd, 0);
    run_op(8'h55, 8'h22, lat, bc);
    chk("post-rst latency", lat, W);
    chk("post-rst diff", 32'(sif.diff), 32'h33);

    // random sweep, back-to-back through the DONE cycle
    for (int i = 0; i < 3000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, lat, bc);
      if (lat != W) chk("rand latency", lat, W);
      chk_model($sformatf("rand %0h-%0h", ra, rb), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
